mdu_iter: RTL and testbench



---
 rtl/mdu_iter_pkg.sv | 20 ++
 rtl/mdu_datapath.sv | 52 +++++
 rtl/mdu_iter.sv | 126 ++++++++++++
 tb/tb_mdu_iter.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/mdu_iter_pkg.sv
// Shared encodings for the iterative multiply/divide unit: op codes,
// FSM states, datapath modes and the divide-by-zero quotient.
package mdu_iter_pkg;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIN  = 2'd2;

  localparam logic MODE_MUL = 1'b0;
  localparam logic MODE_DIV = 1'b1;

  // All-ones quotient for divide by zero; sliced down to the unit width.
  localparam logic [63:0] DIV0_QUO = '1;

endpackage

// File: rtl/mdu_datapath.sv
// Shared 2*WIDTH accumulator: shift-add multiply or restoring divide,
// one bit per enabled step on unsigned magnitudes.
module mdu_datapath
  import mdu_iter_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               step,
  input  logic               mode,
  input  logic [WIDTH-1:0]   opa,
  input  logic [WIDTH-1:0]   opb,
  output logic [2*WIDTH-1:0] acc
);

  logic [WIDTH-1:0]   opb_q;
  logic [WIDTH:0]     add_sum;
  logic [WIDTH:0]     rem_shift;
  logic               fits;
  logic [WIDTH-1:0]   diff;
  logic [2*WIDTH-1:0] acc_next;

  // Multiply keeps the multiplier in the low half and shifts right; divide
  // keeps the dividend in the low half and shifts quotient bits in from the right.
  always_comb begin
    add_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opb_q} : '0);
    rem_shift = acc[2*WIDTH-1:WIDTH-1];
    fits      = rem_shift >= {1'b0, opb_q};
    diff      = rem_shift[WIDTH-1:0] - opb_q;
    if (mode == MODE_DIV) begin
      if (fits) acc_next = {diff, acc[WIDTH-2:0], 1'b1};
      else      acc_next = {rem_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end else begin
      acc_next = {add_sum, acc[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      acc   <= '0;
      opb_q <= '0;
    end else if (load) begin
      acc   <= {{WIDTH{1'b0}}, opa};
      opb_q <= opb;
    end else if (step) begin
      acc   <= acc_next;
    end
  end

endmodule

// File: rtl/mdu_iter.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
// Every op takes a fixed 33 edges from start to the done pulse.
module mdu_iter
  import mdu_iter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  logic [1:0]         state;
  logic [CNT_W-1:0]   cnt;
  logic               is_div_q;
  logic               neg_res_q;
  logic               neg_rem_q;
  logic               div0_q;
  logic [WIDTH-1:0]   a_q;

  logic               is_div;
  logic               is_signed;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic               load;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   res_hi;
  logic [WIDTH-1:0]   res_lo;

  always_comb begin
    is_div    = (op == OP_DIV) || (op == OP_DIVU);
    is_signed = (op == OP_MULT) || (op == OP_DIV);
    mag_a     = (is_signed && a[WIDTH-1]) ? -a : a;
    mag_b     = (is_signed && b[WIDTH-1]) ? -b : b;
    load      = (state == S_IDLE) && start;
  end

  mdu_datapath #(.WIDTH(WIDTH)) u_datapath (
    .clk   (clk),
    .reset (reset),
    .load  (load),
    .step  (state == S_RUN),
    .mode  (is_div_q ? MODE_DIV : MODE_MUL),
    .opa   (mag_a),
    .opb   (mag_b),
    .acc   (acc)
  );

  // Sign fix-up: remainder follows the dividend, quotient/product the xor of signs.
  always_comb begin
    prod   = neg_res_q ? -acc : acc;
    res_hi = prod[2*WIDTH-1:WIDTH];
    res_lo = prod[WIDTH-1:0];
    if (is_div_q) begin
      if (div0_q) begin
        res_hi = a_q;
        res_lo = DIV0_QUO[WIDTH-1:0];
      end else begin
        res_hi = neg_rem_q ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
        res_lo = neg_res_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      hi        <= '0;
      lo        <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      div0_q    <= 1'b0;
      a_q       <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state     <= S_RUN;
            cnt       <= '0;
            busy      <= 1'b1;
            is_div_q  <= is_div;
            neg_res_q <= is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_rem_q <= is_signed && is_div && a[WIDTH-1];
            div0_q    <= is_div && (b == '0);
            a_q       <= a;
          end else begin
            if (hi_we) hi <= wdata;
            if (lo_we) lo <= wdata;
          end
        end
        S_RUN: begin
          cnt <= cnt + 1'b1;
          if (cnt == LAST_CNT) state <= S_FIN;
        end
        S_FIN: begin
          hi    <= res_hi;
          lo    <= res_lo;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_iter.sv
// Scoreboard bench for mdu_iter: stimulus pushes expected HI/LO and done cycle,
// an independent monitor pops and compares on every done pulse.
module tb_mdu_iter;
  import mdu_iter_pkg::*;

  logic        clk;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  typedef struct {
    string       name;
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   cyc;
  int   checks;
  int   errors;

  mdu_iter #(.WIDTH(32), .CNT_W(5)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .hi_we (hi_we),
    .lo_we (lo_we),
    .wdata (wdata),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (reset === 1'b1 && done === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_done: got done=1 at cycle %0d, expected no pending op", cyc);
      end else begin
        mon_e = sb.pop_front();
        checkOutput({mon_e.name, "_hi"}, 64'(hi), 64'(mon_e.hi));
        checkOutput({mon_e.name, "_lo"}, 64'(lo), 64'(mon_e.lo));
        checkOutput({mon_e.name, "_latency"}, 64'(cyc), 64'(mon_e.cyc));
      end
    end
  end

  task automatic applyStimulus(input string name, input logic [1:0] op_in,
                               input logic [31:0] a_in, input logic [31:0] b_in,
                               input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                               input bit disturb, input bit same_we);
    exp_t e;
    @(negedge clk);
    start = 1'b1;
    op    = op_in;
    a     = a_in;
    b     = b_in;
    if (same_we) begin
      lo_we = 1'b1;
      wdata = 32'h0BAD_F00D;
    end
    e.name = name;
    e.hi   = exp_hi;
    e.lo   = exp_lo;
    e.cyc  = cyc + 34;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    lo_we = 1'b0;
    a     = $urandom;
    b     = $urandom;
    op    = 2'($urandom_range(0, 3));
    checkOutput({name, "_busy_after_e0"}, 64'(busy), 64'd1);
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      if (disturb && i == 4) begin
        start = 1'b1;
        hi_we = 1'b1;
        lo_we = 1'b1;
        wdata = 32'hCAFE_F00D;
      end else begin
        start = 1'b0;
        hi_we = 1'b0;
        lo_we = 1'b0;
      end
    end
    checkOutput({name, "_busy_after_e32"}, 64'(busy), 64'd1);
    @(negedge clk);
    checkOutput({name, "_busy_after_e33"}, 64'(busy), 64'd0);
    @(negedge clk);
    checkOutput({name, "_done_one_cycle"}, 64'(done), 64'd0);
  endtask

  initial begin
    cyc    = 0;
    checks = 0;
    errors = 0;
    reset  = 1'b0;
    start  = 1'b0;
    op     = OP_MULT;
    a      = '0;
    b      = '0;
    hi_we  = 1'b0;
    lo_we  = 1'b0;
    wdata  = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset_busy", 64'(busy), 64'd0);
    checkOutput("reset_done", 64'(done), 64'd0);
    checkOutput("reset_hi", 64'(hi), 64'd0);
    checkOutput("reset_lo", 64'(lo), 64'd0);
    reset = 1'b1;

    applyStimulus("mult_neg1x2",  OP_MULT,  32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0, 0);
    applyStimulus("multu_maxx2",  OP_MULTU, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 32'hFFFF_FFFE, 0, 0);
    applyStimulus("mult_neg3xneg7", OP_MULT, 32'hFFFF_FFFD, 32'hFFFF_FFF9, 32'h0000_0000, 32'h0000_0015, 0, 0);
    applyStimulus("divu_100_7",   OP_DIVU,  32'd100,       32'd7,         32'h0000_0002, 32'h0000_000E, 0, 0);
    applyStimulus("divu_max_10",  OP_DIVU,  32'hFFFF_FFFF, 32'd10,        32'h0000_0005, 32'h1999_9999, 0, 0);
    applyStimulus("div_neg7_2",   OP_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 0, 0);
    applyStimulus("div_7_neg2",   OP_DIV,   32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 0, 0);
    applyStimulus("div_overflow", OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 0, 0);
    applyStimulus("divu_by_zero", OP_DIVU,  32'h1234_5678, 32'd0,         32'h1234_5678, 32'hFFFF_FFFF, 1, 0);
    applyStimulus("div_by_zero",  OP_DIV,   32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF, 0, 0);

    // MTHI then MTLO in IDLE, each visible the following cycle.
    hi_we = 1'b1;
    wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    hi_we = 1'b0;
    checkOutput("mthi_hi", 64'(hi), 64'h0000_0000_DEAD_BEEF);
    checkOutput("mthi_lo_kept", 64'(lo), 64'h0000_0000_FFFF_FFFF);
    lo_we = 1'b1;
    wdata = 32'h1357_9BDF;
    @(negedge clk);
    lo_we = 1'b0;
    checkOutput("mtlo_lo", 64'(lo), 64'h0000_0000_1357_9BDF);
    checkOutput("mtlo_hi_kept", 64'(hi), 64'h0000_0000_DEAD_BEEF);

    applyStimulus("start_beats_mtlo", OP_MULTU, 32'd3, 32'd5, 32'h0000_0000, 32'h0000_000F, 0, 1);

    // Reset sampled at E10 of an in-flight MULT discards it.
    @(negedge clk);
    start = 1'b1;
    op    = OP_MULT;
    a     = 32'd7;
    b     = 32'hFFFF_FFFD;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("midop_reset_busy", 64'(busy), 64'd0);
    checkOutput("midop_reset_done", 64'(done), 64'd0);
    checkOutput("midop_reset_hi", 64'(hi), 64'd0);
    checkOutput("midop_reset_lo", 64'(lo), 64'd0);
    reset = 1'b1;

    applyStimulus("mult_after_reset", OP_MULT, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 0, 0);

    for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge clk);
    checkOutput("scoreboard_drain", 64'(sb.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
